// File: rtl/char_redraw_scheduler_pkg.sv
// char_pkg: screen geometry and scheduler state shared with the text renderer.
package char_pkg;
   localparam int SCREEN_CHAR_W = 40;
   localparam int SCREEN_CHAR_H = 30;
   localparam int SCREEN_CHAR_TOTAL = SCREEN_CHAR_W * SCREEN_CHAR_H;
   localparam int IDX_W = 11;
   typedef enum logic [1:0] {SCAN, READ, ISSUE} state_t;
   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
      return (i == IDX_W'(SCREEN_CHAR_TOTAL - 1)) ? '0 : i + 1'b1;
   endfunction
endpackage

// File: rtl/char_redraw_scheduler_if.sv
// char_redraw_scheduler_if: host write port, renderer handshake and status.
interface char_redraw_scheduler_if;
   import char_pkg::*;
   logic             chr_wr;
   logic [IDX_W-1:0] chr_idx;
   logic [7:0]       chr_code;
   logic             full_redraw;
   logic             render_req;
   logic [IDX_W-1:0] render_idx;
   logic [7:0]       render_code;
   logic             render_ack;
   logic [IDX_W-1:0] dirty_count;
   logic             idle;
   modport master (output chr_wr, chr_idx, chr_code, full_redraw, render_ack,
                   input render_req, render_idx, render_code, dirty_count, idle);
   modport slave (input chr_wr, chr_idx, chr_code, full_redraw, render_ack,
                  output render_req, render_idx, render_code, dirty_count, idle);
endinterface

// File: rtl/char_redraw_scheduler_ram.sv
// char_ram: 1200x8 character map, one write and one registered read per cycle.
module char_ram
   import char_pkg::*;
(
   input  logic             clk,
   input  logic             i_we,
   input  logic [IDX_W-1:0] i_waddr,
   input  logic [7:0]       i_wdata,
   input  logic [IDX_W-1:0] i_raddr,
   output logic [7:0]       o_rdata
);
   logic [7:0] r_mem [SCREEN_CHAR_TOTAL];
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      o_rdata <= r_mem[i_raddr];
   end
endmodule

// File: rtl/char_redraw_scheduler.sv
// char_redraw_scheduler: tracks dirty cells and feeds them round-robin to the glyph renderer.
module char_redraw_scheduler
   import char_pkg::*;
#(
   parameter int FULL_REDRAW_ON_RESET = 1
) (
   input logic pclk,
   input logic rst_n,
   char_redraw_scheduler_if.slave bus
);
   state_t                       r_state, w_state_nxt;
   logic [IDX_W-1:0]             r_ptr, r_idx, r_count, w_ptr_nxt, w_count_nxt;
   logic [7:0]                   r_code, w_rdata;
   logic                         r_req;
   logic [SCREEN_CHAR_TOTAL-1:0] r_dirty;
   logic                         w_wr_ok, w_clr, w_load, w_done, w_set_new, w_clr_eff;

   assign w_wr_ok = bus.chr_wr && (bus.chr_idx < IDX_W'(SCREEN_CHAR_TOTAL));

   char_ram u_ram (
      .clk     (pclk),
      .i_we    (w_wr_ok),
      .i_waddr (bus.chr_idx),
      .i_wdata (bus.chr_code),
      .i_raddr (r_ptr),
      .o_rdata (w_rdata)
   );

   // A host write to the cell being cleared wins, so that cell's count is unchanged.
   always_comb begin
      w_clr = (r_state == SCAN) && r_dirty[r_ptr];
      w_load = (r_state == READ);
      w_done = (r_state == ISSUE) && bus.render_ack;
      w_state_nxt = w_clr ? READ : w_load ? ISSUE : w_done ? SCAN : r_state;
      w_ptr_nxt = (((r_state == SCAN) && !w_clr) || w_done) ? next_idx(r_ptr) : r_ptr;
      w_set_new = w_wr_ok && !r_dirty[bus.chr_idx];
      w_clr_eff = w_clr && !(w_wr_ok && (bus.chr_idx == r_ptr));
      w_count_nxt = r_count + IDX_W'(w_set_new) - IDX_W'(w_clr_eff);
   end

   always_ff @(posedge pclk) begin
      if (!rst_n) begin
         r_state <= SCAN;
         r_ptr <= '0;
         r_req <= 1'b0;
         r_idx <= '0;
         r_code <= '0;
         r_dirty <= {SCREEN_CHAR_TOTAL{FULL_REDRAW_ON_RESET != 0}};
         r_count <= (FULL_REDRAW_ON_RESET != 0) ? IDX_W'(SCREEN_CHAR_TOTAL) : '0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr <= w_ptr_nxt;
         if (w_load) begin
            r_req <= 1'b1;
            r_idx <= r_ptr;
            r_code <= w_rdata;
         end else if (w_done) r_req <= 1'b0;
         if (bus.full_redraw) begin
            r_dirty <= '1;
            r_count <= IDX_W'(SCREEN_CHAR_TOTAL);
         end else begin
            if (w_clr) r_dirty[r_ptr] <= 1'b0;
            if (w_wr_ok) r_dirty[bus.chr_idx] <= 1'b1;
            r_count <= w_count_nxt;
         end
      end
   end

   assign bus.render_req = r_req;
   assign bus.render_idx = r_idx;
   assign bus.render_code = r_code;
   assign bus.dirty_count = r_count;
   assign bus.idle = (r_count == '0) && !r_req;
endmodule

// File: tb/tb_char_redraw_scheduler.sv
// tb_char_redraw_scheduler: directed scenario tasks with hand-computed expectations.
module tb_char_redraw_scheduler;
   logic pclk = 1'b0;
   logic rst_n = 1'b0;
   int errs = 0;
   int checks = 0;
   logic [10:0] gi;
   logic [7:0] gc;

   char_redraw_scheduler_if bus ();
   char_redraw_scheduler dut (.pclk(pclk), .rst_n(rst_n), .bus(bus.slave));

   always #5 pclk = ~pclk;

   task automatic step();
      @(posedge pclk);
      #1;
   endtask

   task automatic wr(input logic [10:0] i, input logic [7:0] c);
      bus.chr_wr = 1'b1;
      bus.chr_idx = i;
      bus.chr_code = c;
      step();
      bus.chr_wr = 1'b0;
   endtask

   task automatic ack();
      bus.render_ack = 1'b1;
      step();
      bus.render_ack = 1'b0;
   endtask

   task automatic get_req(output logic [10:0] i, output logic [7:0] c);
      int n = 0;
      while (!bus.render_req && n < 3000) begin
         step();
         n++;
      end
      checks++;
      if (bus.render_req !== 1'b1) begin
         errs++;
         $display("FAIL get_req: render_req=%b after %0d cycles, required 1", bus.render_req, n);
      end
      i = bus.render_idx;
      c = bus.render_code;
   endtask

   task automatic test_reset();
      int n = 1;
      int bad = 0;
      int cyc = 0;
      rst_n = 1'b0;
      bus.render_ack = 1'b1;
      step();
      step();
      checks += 5;
      if (bus.render_req !== 1'b0) begin errs++; $display("FAIL rst_req: got %b want 0", bus.render_req); end
      if (bus.render_idx !== 11'd0) begin errs++; $display("FAIL rst_idx: got %0d want 0", bus.render_idx); end
      if (bus.render_code !== 8'h00) begin errs++; $display("FAIL rst_code: got %h want 00", bus.render_code); end
      if (bus.dirty_count !== 11'd1200) begin errs++; $display("FAIL rst_count: got %0d want 1200", bus.dirty_count); end
      if (bus.idle !== 1'b0) begin errs++; $display("FAIL rst_idle: got %b want 0", bus.idle); end
      rst_n = 1'b1;
      step();
      checks++;
      if (bus.render_req !== 1'b0) begin errs++; $display("FAIL early_req: got %b want 0", bus.render_req); end
      step();
      checks += 3;
      if (bus.render_req !== 1'b1) begin errs++; $display("FAIL first_req: got %b want 1", bus.render_req); end
      if (bus.render_idx !== 11'd0) begin errs++; $display("FAIL first_idx: got %0d want 0", bus.render_idx); end
      if (bus.render_code !== 8'h00) begin errs++; $display("FAIL first_code: got %h want 00", bus.render_code); end
      while (n < 1200 && cyc < 5000) begin
         step();
         cyc++;
         if (bus.render_req) begin
            if (bus.render_idx !== 11'(n)) bad++;
            n++;
         end
      end
      step();
      bus.render_ack = 1'b0;
      checks += 3;
      if (bad != 0 || n != 1200) begin errs++; $display("FAIL reset_order: %0d out-of-order, %0d requests, want 0 and 1200", bad, n); end
      if (bus.idle !== 1'b1) begin errs++; $display("FAIL reset_idle: got %b want 1", bus.idle); end
      if (bus.dirty_count !== 11'd0) begin errs++; $display("FAIL reset_count: got %0d want 0", bus.dirty_count); end
   endtask

   task automatic test_single();
      int unstable = 0;
      int extra = 0;
      wr(11'd37, 8'h41);
      get_req(gi, gc);
      checks += 2;
      if (gi !== 11'd37) begin errs++; $display("FAIL single_idx: got %0d want 37", gi); end
      if (gc !== 8'h41) begin errs++; $display("FAIL single_code: got %h want 41", gc); end
      repeat (5) begin
         step();
         if (bus.render_req !== 1'b1 || bus.render_idx !== 11'd37 || bus.render_code !== 8'h41) unstable++;
      end
      ack();
      repeat (1300) begin
         if (bus.render_req) extra++;
         step();
      end
      checks += 3;
      if (unstable != 0) begin errs++; $display("FAIL single_stable: %0d unstable cycles, want 0", unstable); end
      if (extra != 0) begin errs++; $display("FAIL single_extra: %0d extra request cycles, want 0", extra); end
      if (bus.idle !== 1'b1) begin errs++; $display("FAIL single_idle: got %b want 1", bus.idle); end
   endtask

   task automatic test_wrap();
      wr(11'd1198, 8'h11);
      get_req(gi, gc);
      wr(11'd1199, 8'h12);
      wr(11'd0, 8'h13);
      checks++;
      if (gi !== 11'd1198) begin errs++; $display("FAIL wrap_a: got %0d want 1198", gi); end
      ack();
      get_req(gi, gc);
      checks += 2;
      if (gi !== 11'd1199) begin errs++; $display("FAIL wrap_b_idx: got %0d want 1199", gi); end
      if (gc !== 8'h12) begin errs++; $display("FAIL wrap_b_code: got %h want 12", gc); end
      ack();
      get_req(gi, gc);
      checks += 2;
      if (gi !== 11'd0) begin errs++; $display("FAIL wrap_c_idx: got %0d want 0", gi); end
      if (gc !== 8'h13) begin errs++; $display("FAIL wrap_c_code: got %h want 13", gc); end
      ack();
   endtask

   task automatic test_inflight_write();
      wr(11'd5, 8'h20);
      get_req(gi, gc);
      checks++;
      if (gi !== 11'd5 || gc !== 8'h20) begin errs++; $display("FAIL inflight_first: got %0d/%h want 5/20", gi, gc); end
      wr(11'd5, 8'h42);
      checks += 2;
      if (bus.render_idx !== 11'd5 || bus.render_code !== 8'h20 || bus.render_req !== 1'b1) begin
         errs++;
         $display("FAIL inflight_hold: got %b %0d/%h want 1 5/20", bus.render_req, bus.render_idx, bus.render_code);
      end
      if (bus.dirty_count !== 11'd1) begin errs++; $display("FAIL inflight_count: got %0d want 1", bus.dirty_count); end
      ack();
      get_req(gi, gc);
      checks++;
      if (gi !== 11'd5 || gc !== 8'h42) begin errs++; $display("FAIL inflight_redo: got %0d/%h want 5/42", gi, gc); end
      ack();
   endtask

   task automatic test_full_redraw();
      int n = 0;
      int bad = 0;
      int cyc = 0;
      wr(11'd10, 8'h33);
      get_req(gi, gc);
      bus.full_redraw = 1'b1;
      step();
      bus.full_redraw = 1'b0;
      checks += 2;
      if (bus.dirty_count !== 11'd1200) begin errs++; $display("FAIL full_count: got %0d want 1200", bus.dirty_count); end
      if (bus.render_req !== 1'b1 || bus.render_idx !== 11'd10) begin
         errs++;
         $display("FAIL full_hold: got %b/%0d want 1/10", bus.render_req, bus.render_idx);
      end
      ack();
      bus.render_ack = 1'b1;
      while (n < 1200 && cyc < 5000) begin
         step();
         cyc++;
         if (bus.render_req) begin
            if (bus.render_idx !== 11'((11 + n) % 1200)) bad++;
            n++;
         end
      end
      step();
      bus.render_ack = 1'b0;
      checks += 2;
      if (bad != 0 || n != 1200) begin errs++; $display("FAIL full_order: %0d out-of-order, %0d requests, want 0 and 1200", bad, n); end
      if (bus.idle !== 1'b1 || bus.dirty_count !== 11'd0) begin
         errs++;
         $display("FAIL full_idle: got idle=%b count=%0d want 1/0", bus.idle, bus.dirty_count);
      end
   endtask

   task automatic test_out_of_range();
      int busy = 0;
      wr(11'd1200, 8'h55);
      wr(11'd2047, 8'h66);
      repeat (1300) begin
         if (bus.render_req || !bus.idle) busy++;
         step();
      end
      checks += 2;
      if (busy != 0) begin errs++; $display("FAIL oor_busy: %0d non-idle cycles, want 0", busy); end
      if (bus.dirty_count !== 11'd0) begin errs++; $display("FAIL oor_count: got %0d want 0", bus.dirty_count); end
   endtask

   task automatic test_reset_in_issue();
      wr(11'd3, 8'h77);
      get_req(gi, gc);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      checks += 3;
      if (bus.render_req !== 1'b0) begin errs++; $display("FAIL midrst_req: got %b want 0", bus.render_req); end
      if (bus.render_idx !== 11'd0 || bus.render_code !== 8'h00) begin
         errs++;
         $display("FAIL midrst_out: got %0d/%h want 0/00", bus.render_idx, bus.render_code);
      end
      if (bus.dirty_count !== 11'd1200) begin errs++; $display("FAIL midrst_count: got %0d want 1200", bus.dirty_count); end
   endtask

   initial begin
      bus.chr_wr = 1'b0;
      bus.chr_idx = '0;
      bus.chr_code = '0;
      bus.full_redraw = 1'b0;
      bus.render_ack = 1'b0;
      test_reset();
      test_single();
      test_wrap();
      test_inflight_write();
      test_full_redraw();
      test_out_of_range();
      test_reset_in_issue();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/char_redraw_scheduler.md
Name: char_redraw_scheduler

Overview:
Owns the 40x30 screen character map and decides which cells the glyph renderer redraws into the VGA framebuffer, and in what order. Takes single-cell character writes from the host/ioctl side and marks each written cell dirty. A round-robin scanner finds dirty cells and hands them one at a time to the renderer over a req/ack handshake. This replaces the current brute-force redraw of all 1200 cells every pass.

Parameters:
SCREEN_CHAR_TOTAL, 1200, number of character cells (40x30 at SCALE 2)
IDX_W, 11, width of a cell index
FULL_REDRAW_ON_RESET, 1, if 1 every cell is dirty after reset; if 0 no cell is dirty

Ports:
pclk  in  1  pixel clock; sole clock
rst_n  in  1  reset, synchronous, active-low
chr_wr  in  1  host character write strobe, one cell per cycle
chr_idx  in  IDX_W  cell index for chr_wr; valid range 0..SCREEN_CHAR_TOTAL-1
chr_code  in  8  character code written to chr_idx
full_redraw  in  1  one-cycle pulse; marks all cells dirty
render_req  out  1  request to renderer to draw cell render_idx
render_idx  out  IDX_W  cell index being requested
render_code  out  8  character code of render_idx
render_ack  in  1  renderer has finished drawing the requested cell
dirty_count  out  IDX_W  number of dirty cells, excluding the one in flight
idle  out  1  high when no cell is dirty and no request is outstanding

Behaviour:
- Clocking and reset: single clock pclk; rst_n is synchronous, active-low.
- Reset values (rst_n low at a pclk edge):
  - render_req=0, render_idx=0, render_code=0, scan_ptr=0, state=SCAN.
  - Dirty bits all 1 if FULL_REDRAW_ON_RESET, else all 0.
  - dirty_count = 1200 or 0 to match; idle = !FULL_REDRAW_ON_RESET.
- Character RAM: 1200x8, synchronous read, 1-cycle latency. Not cleared by reset; configuration-time contents are 0x00.
- Dirty map: 1200 flops, so full_redraw can set all of them in one cycle.
- Host writes:
  - chr_wr writes chr_code into RAM[chr_idx] and sets dirty[chr_idx]. Both take effect at the next edge and are accepted in any state.
  - chr_idx >= SCREEN_CHAR_TOTAL: ignored, no RAM or dirty change.
- State SCAN:
  - Each cycle, test dirty[scan_ptr].
  - Clean: scan_ptr advances; 1199 wraps to 0.
  - Dirty: clear dirty[scan_ptr], start RAM read of scan_ptr, go to READ.
- State READ (1 cycle):
  - Load render_idx=scan_ptr and render_code=RAM data.
  - Set render_req=1 and go to ISSUE.
- State ISSUE:
  - render_req, render_idx and render_code are held stable until render_ack is sampled high.
  - On that edge: render_req=0, scan_ptr advances with wrap, go to SCAN.
  - Ack may arrive in the first ISSUE cycle.
  - render_ack outside ISSUE is ignored.
- Minimum cost: 3 cycles per dirty cell (SCAN, READ, ISSUE with immediate ack).
- Priority when events coincide on the same cell and edge: set wins over clear.
  - chr_wr to the cell being cleared in SCAN leaves it dirty; it is redrawn later with the new code.
  - chr_wr to the cell in READ/ISSUE updates RAM and re-marks it dirty. The in-flight request keeps its latched code; the cell is redrawn on a later pass.
  - full_redraw in any state sets every bit, including the in-flight cell. It does not abort the outstanding request.
  - chr_wr and full_redraw in the same cycle: RAM write performed, all bits set.
- dirty_count:
  - Equals the popcount of the dirty map; updated every cycle with the set/clear rules above.
  - After full_redraw it reads 1200 on the following cycle.
  - Never exceeds 1200 and never underflows.
- idle = (dirty_count==0) && !render_req.
- Reset mid-ISSUE: render_req drops at that edge; the renderer must abandon the cell.

Decomposition:
- Package char_pkg:
  - SCREEN_CHAR_W=40, SCREEN_CHAR_H=30, SCREEN_CHAR_TOTAL=1200, IDX_W=11.
  - State enum {SCAN, READ, ISSUE}.
  - Shared with the text renderer.
- Sub-module char_ram: 1200x8 single-write, single-read synchronous RAM.
- Dirty map, scanner FSM and counter stay in the top module.

Test Plan:
- Reset with FULL_REDRAW_ON_RESET=1, render_ack tied high:
  - render_req first high 2 cycles after rst_n rises, render_idx=0, render_code=0x00.
  - 1200 requests issued in index order 0..1199, then idle=1 and dirty_count=0.
- From idle with ack held low until 5 cycles after req: chr_wr idx=37, code=0x41:
  - exactly one request, idx=37, code=0x41, outputs stable for all 6 ISSUE cycles, then idle=1.
- Writes to idx 1199 then idx 0 with scan_ptr at 1199:
  - requests in order 1199, then 0; wrap verified.
- While ISSUE holds idx 5 with code 0x20, chr_wr idx=5, code=0x42:
  - current request completes with 0x20; a later request for idx 5 carries 0x42.
- full_redraw pulse during ISSUE of idx 10:
  - dirty_count=1200 the next cycle; idx 10 completes, then all 1200 cells, including 10, are requested again.
- chr_wr idx=1200 and idx=2047:
  - no request issued, dirty_count unchanged at 0, idle stays 1.
